// File: rtl/tt_uio_pkg.sv
// Shared types, widths and round-robin helper for the uio pin-bank arbiter
// and the pin-sharing blocks that reuse its priority encoder.
package tt_uio_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_e;

  // Next index in rotation order, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/tt_uio_arbiter_if.sv
// Requester-side and pad-side signals of the uio pin-bank arbiter.
interface tt_uio_arbiter_if
  import tt_uio_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic                      ena;
  logic [N_REQ-1:0]          req;
  logic [N_REQ-1:0]          dir;
  logic [N_REQ-1:0]          last;
  logic [DATA_W*N_REQ-1:0]   wdata;
  logic [N_REQ-1:0]          grant;
  logic [IDX_W-1:0]          owner;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [DATA_W-1:0]         uio_in;
  logic [DATA_W-1:0]         uio_out;
  logic [DATA_W-1:0]         uio_oe;

  modport slave (
    input  ena, req, dir, last, wdata, uio_in,
    output grant, owner, rdata, busy, uio_out, uio_oe
  );

  modport master (
    output ena, req, dir, last, wdata, uio_in,
    input  grant, owner, rdata, busy, uio_out, uio_oe
  );

endinterface

// File: rtl/tt_uio_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request after i_last.
module rr_pick
  import tt_uio_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid_c,
  output logic [IW-1:0] o_idx_c
);

  int unsigned w_cand;

  // Walk last+1, last+2, ... wrapping; i_last itself is tried last.
  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    w_cand    = 32'(i_last);
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = rr_next(w_cand, N);
      if (!o_valid_c && i_req[IW'(w_cand)]) begin
        o_valid_c = 1'b1;
        o_idx_c   = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/tt_uio_arbiter.sv
// Round-robin owner arbitration for the shared uio pin bank, with an
// output-enable turnaround gap on input-to-output switches and tenure capping.
module tt_uio_arbiter
  import tt_uio_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned TURN_CYC = 2
) (
  input logic             clk,
  input logic             rst_n,
  tt_uio_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int unsigned TURN_W = $clog2(TURN_CYC + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    w_owner_nxt;
  logic                r_sel_dir;
  logic                w_sel_dir_nxt;
  logic                r_cur_dir;
  logic                w_cur_dir_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [TURN_W-1:0]   r_turn_cnt;
  logic [TURN_W-1:0]   w_turn_nxt;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    w_grant_nxt;
  logic [DATA_W-1:0]   r_uio_out;
  logic [DATA_W-1:0]   w_uio_out_nxt;
  logic [DATA_W-1:0]   r_uio_oe;
  logic [DATA_W-1:0]   w_uio_oe_nxt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;

  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_dir;
  logic [N_REQ-1:0]    w_own_oh;
  logic                w_others;
  logic                w_hold_max;
  logic                w_release;
  logic [DATA_W-1:0]   w_wdata [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wdata
    assign w_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .i_req     (bus.req),
    .i_last    (r_owner),
    .o_valid_c (w_pick_valid),
    .o_idx_c   (w_pick_idx)
  );

  assign w_pick_dir = bus.dir[w_pick_idx];
  assign w_own_oh   = N_REQ'(1) << r_owner;
  assign w_others   = |(bus.req & ~w_own_oh);
  assign w_hold_max = (r_hold_cnt == HOLD_W'(MAX_HOLD));
  // Preemption only applies once the tenure cap is reached and someone waits.
  assign w_release  = (bus.last[r_owner] & r_grant[r_owner]) |
                      ~bus.req[r_owner] |
                      (w_hold_max & w_others);

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_sel_dir_nxt = r_sel_dir;
    w_cur_dir_nxt = r_cur_dir;
    w_hold_nxt    = r_hold_cnt;
    w_turn_nxt    = r_turn_cnt;
    w_grant_nxt   = '0;
    w_uio_out_nxt = r_uio_out;
    w_uio_oe_nxt  = r_uio_oe;

    unique case (r_state)
      IDLE: begin
        if (bus.ena && w_pick_valid) begin
          w_owner_nxt   = w_pick_idx;
          w_sel_dir_nxt = w_pick_dir;
          if (w_pick_dir && !r_cur_dir) begin
            // Pins were inputs: hold them released before anyone drives.
            w_state_nxt  = TURN;
            w_turn_nxt   = '0;
            w_uio_oe_nxt = '0;
          end else begin
            w_state_nxt   = OWN;
            w_cur_dir_nxt = w_pick_dir;
            w_hold_nxt    = HOLD_W'(1);
            w_uio_oe_nxt  = {DATA_W{w_pick_dir}};
            w_grant_nxt   = N_REQ'(1) << w_pick_idx;
          end
        end
      end

      TURN: begin
        w_uio_oe_nxt = '0;
        if (r_turn_cnt == TURN_W'(TURN_CYC - 1)) begin
          w_state_nxt   = OWN;
          w_cur_dir_nxt = r_sel_dir;
          w_hold_nxt    = HOLD_W'(1);
          w_uio_oe_nxt  = {DATA_W{r_sel_dir}};
          w_grant_nxt   = w_own_oh;
        end else begin
          w_turn_nxt = r_turn_cnt + TURN_W'(1);
        end
      end

      OWN: begin
        w_uio_out_nxt = w_wdata[r_owner];
        if (w_release) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_grant_nxt = r_grant;
          if (!w_hold_max) begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= IDX_W'(N_REQ - 1);
      r_sel_dir  <= 1'b0;
      r_cur_dir  <= 1'b0;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_grant    <= '0;
      r_uio_out  <= '0;
      r_uio_oe   <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_sel_dir  <= w_sel_dir_nxt;
      r_cur_dir  <= w_cur_dir_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_grant    <= w_grant_nxt;
      r_uio_out  <= w_uio_out_nxt;
      r_uio_oe   <= w_uio_oe_nxt;
      r_rdata    <= bus.uio_in;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign bus.grant   = r_grant;
  assign bus.owner   = r_owner;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = r_busy;
  assign bus.uio_out = r_uio_out;
  assign bus.uio_oe  = r_uio_oe;

endmodule

// File: doc/tt_uio_arbiter.md
Name: tt_uio_arbiter

Overview:
- Round-robin arbiter and sequencer for the chip's shared 8-bit bidirectional uio pin bank (uio_in/uio_out/uio_oe).
- Up to N_REQ internal requesters each ask for the bank, declaring direction (drive or sample). The block grants one owner at a time, enforces a bus-turnaround gap before switching the pins from input to output, and caps each tenure.
- Instantiated directly under tt_um_uabc_prueba2024; its uio_* outputs connect straight to the top-level ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum OWN cycles per grant while another requester waits (>=1).
- TURN_CYC, 2, cycles uio_oe is held 0 on an input-to-output switch (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  low blocks new grants; the current owner is unaffected
- req  in  N_REQ  per-requester request, level
- dir  in  N_REQ  per-requester direction, 1 = drive pins, 0 = sample pins; sampled at grant
- last  in  N_REQ  owner's final cycle, qualified by grant
- wdata  in  8*N_REQ  per-requester drive data; slice i = bits [8i+7:8i]
- grant  out  N_REQ  one-hot owner, registered
- owner  out  $clog2(N_REQ)  index of current or most recent owner
- rdata  out  8  registered copy of uio_in, updated every cycle
- busy  out  1  state != IDLE
- uio_in  in  8  pad inputs
- uio_out  out  8  pad outputs
- uio_oe  out  8  pad enables (all bits equal)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, owner=N_REQ-1 (so requester 0 has first priority), uio_out=0, uio_oe=0, rdata=0, busy=0, hold_cnt=0, turn_cnt=0, cur_dir=0.
- States:
  - IDLE:
    - If ena=1 and any req, select the first requester set in rotation order owner+1, owner+2, ... (mod N_REQ). Latch its index into owner and its dir into sel_dir.
    - If sel_dir=1 and cur_dir=0, go to TURN. Otherwise go to OWN.
    - uio_oe and uio_out hold their last values in IDLE.
  - TURN:
    - uio_oe=0, grant=0.
    - Count TURN_CYC cycles, then go to OWN with cur_dir=1.
  - OWN:
    - grant[owner]=1 and cur_dir=sel_dir.
    - uio_oe = {8{cur_dir}}.
    - uio_out <= wdata[owner], registered, so the pin lags wdata by 1 cycle.
    - hold_cnt counts up from 1.
- Release from OWN to IDLE, grant dropped the next cycle:
  - (last[owner] & grant[owner]); or
  - req[owner]=0; or
  - hold_cnt==MAX_HOLD and any other req is set (preemption).
  - If hold_cnt reaches MAX_HOLD with no other requester waiting, the counter saturates and ownership continues.
- Latency:
  - req to grant: 2 cycles (IDLE decision, then registered grant) with no turnaround, or 2+TURN_CYC with turnaround.
  - Release always costs exactly 1 IDLE cycle.
- Output-to-input switch: no gap. uio_oe falls on the first OWN cycle of the input owner.
- dir changes while in OWN are ignored. Direction is fixed per grant.
- Simultaneous requests: rotation order only. The same requester can win twice in a row only if no other req is set.
- req and last both high on the first OWN cycle gives a one-cycle tenure.
- ena falling during OWN or TURN: the sequence completes; the next IDLE issues no grant.
- Reset mid-OWN: grant and uio_oe drop asynchronously to 0.
- Invariants: $onehot0(grant) holds at all times. grant!=0 only in OWN.

Decomposition:
- Package tt_uio_pkg holds:
  - state enum {IDLE, TURN, OWN} (2 bits);
  - DATA_W=8;
  - the rr_next() function.
- One sub-module, rr_pick: a combinational round-robin priority encoder with inputs req and last index, outputs valid and index. It is reused by later pin-sharing blocks.

Test Plan:
- Reset then req=4'b0001, dir[0]=1 -> TURN for 2 cycles with uio_oe=0; then grant=0001, uio_oe=8'hFF, and uio_out=wdata[0] one cycle later.
- req=4'b1111 held, all dir=0, each asserting last after 3 OWN cycles -> grants in order 0001, 0010, 0100, 1000, 0001, with 1 IDLE cycle between them; uio_oe stays 0.
- Requester 2 holds req with no last, and requester 1 requests -> at hold_cnt=16 grant moves to 1; with requester 1 idle, requester 2 keeps ownership beyond 16 cycles.
- Owner 0 with dir=1 releases, then requester 1 with dir=0 -> no TURN, and uio_oe drops to 0 in requester 1's first OWN cycle. Then requester 2 with dir=1 -> TURN of 2 cycles before it is granted.
- rst_n pulsed low mid-OWN -> grant=0, uio_oe=0, uio_out=0 immediately; after release, requester 0 wins first.
- ena=0 with req=4'b0010 -> no grant and busy=0; ena rising -> grant=0010 two cycles later.
